// File: rtl/register_file_2r1w.sv
// Two-read, one-write general-purpose register file for the single-cycle datapath.
// Register 0 reads as zero; BYPASS selects write-through on a same-cycle read of the write target.
module register_file_2r1w #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DEPTH_LOG2-1:0] RA,
  input  logic [DEPTH_LOG2-1:0] RB,
  input  logic [DEPTH_LOG2-1:0] WA,
  input  logic [WIDTH-1:0]      WD,
  input  logic                  WE,
  output logic [WIDTH-1:0]      RDA,
  output logic [WIDTH-1:0]      RDB,
  output logic [15:0]           WCOUNT
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [15:0]      wcount_q;
  logic [15:0]      wcount_d;
  logic             wr_en;

  assign wr_en    = WE && (WA != '0);
  assign wcount_d = wcount_q + 16'd1;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wcount_q <= '0;
    end else if (wr_en) begin
      regs_q[WA] <= WD;
      wcount_q   <= wcount_d;
    end
  end

  // Bypass is gated by RST_N so a write presented during reset never leaks to the outputs.
  always_comb begin
    RDA = '0;
    if (RST_N && (RA != '0)) begin
      if ((BYPASS != 0) && wr_en && (RA == WA)) begin
        RDA = WD;
      end else begin
        RDA = regs_q[RA];
      end
    end
  end

  always_comb begin
    RDB = '0;
    if (RST_N && (RB != '0)) begin
      if ((BYPASS != 0) && wr_en && (RB == WA)) begin
        RDB = WD;
      end else begin
        RDB = regs_q[RB];
      end
    end
  end

  assign WCOUNT = wcount_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: one write-through and one non-bypassed instance
// share the same stimulus; the ALU-source mux is modelled alongside read port B.
module tb_register_file_2r1w;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra, rb, wa;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rda1, rdb1, rda0, rdb0;
  logic [15:0] wcnt1, wcnt0;
  logic        mux_s;
  logic [31:0] mux_imm;
  logic [31:0] mux_y;

  int errors = 0;
  int checks = 0;

  register_file_2r1w #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1)) dut_byp (
    .CLK(clk), .RST_N(rst_n), .RA(ra), .RB(rb), .WA(wa), .WD(wd), .WE(we),
    .RDA(rda1), .RDB(rdb1), .WCOUNT(wcnt1)
  );

  register_file_2r1w #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(0)) dut_nob (
    .CLK(clk), .RST_N(rst_n), .RA(ra), .RB(rb), .WA(wa), .WD(wd), .WE(we),
    .RDA(rda0), .RDB(rdb0), .WCOUNT(wcnt0)
  );

  assign mux_y = mux_s ? mux_imm : rdb1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ra = 5'd5; rb = 5'd0; wa = 5'd5; wd = 32'hDEADBEEF; we = 1'b1;
    mux_s = 1'b0; mux_imm = 32'h00000010;

    // Reset held: attempted write to reg 5 must be ignored and outputs stay zero.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rda_byp", rda1, 32'h0);
    check("rst_rdb_byp", rdb1, 32'h0);
    check("rst_rda_nob", rda0, 32'h0);
    check("rst_wcount", {16'h0, wcnt1}, 32'h0);
    rb = 5'd5;
    #1;
    check("rst_rdb_r5", rdb1, 32'h0);

    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_r5", rda1, 32'h0);
    @(posedge clk); #1;
    check("post_rst_r5_edge", rda0, 32'h0);
    check("post_rst_wcount", {16'h0, wcnt0}, 32'h0);

    // Basic write and read.
    write_reg(5'd3, 32'h12345678);
    ra = 5'd3; rb = 5'd3;
    #1;
    check("wr3_rda", rda1, 32'h12345678);
    check("wr3_rdb", rdb1, 32'h12345678);
    check("wr3_rda_nob", rda0, 32'h12345678);
    check("wr3_wcount", {16'h0, wcnt1}, 32'd1);

    write_reg(5'd31, 32'hFFFFFFFF);
    rb = 5'd31; ra = 5'd30;
    #1;
    check("wr31_rdb", rdb1, 32'hFFFFFFFF);
    check("r30_zero", rda1, 32'h0);
    check("wr31_wcount", {16'h0, wcnt0}, 32'd2);

    // Register 0 ignores writes and does not bump the counter.
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hA5A5A5A5; ra = 5'd0;
    #1;
    check("r0_before_byp", rda1, 32'h0);
    check("r0_before_nob", rda0, 32'h0);
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("r0_after", rda1, 32'h0);
    check("r0_wcount", {16'h0, wcnt1}, 32'd2);

    // Bypass versus stored value for a same-cycle read of the write target.
    write_reg(5'd7, 32'h11111111);
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'h22222222; ra = 5'd7; rb = 5'd7;
    #1;
    check("byp_rda", rda1, 32'h22222222);
    check("byp_rdb", rdb1, 32'h22222222);
    check("nob_rda_before", rda0, 32'h11111111);
    check("nob_rdb_before", rdb0, 32'h11111111);
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("nob_rda_after", rda0, 32'h22222222);
    check("byp_rda_after", rda1, 32'h22222222);
    check("byp_wcount", {16'h0, wcnt1}, 32'd4);

    // ALU-source mux on read port B.
    write_reg(5'd2, 32'h00000009);
    rb = 5'd2; mux_s = 1'b0;
    #1;
    check("mux_s0", mux_y, 32'h00000009);
    mux_s = 1'b1;
    #1;
    check("mux_s1", mux_y, 32'h00000010);

    // Counter wrap: clear, then 65,536 writes to reg 1.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("clr_wcount", {16'h0, wcnt1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ra = 5'd1;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      we = 1'b1; wa = 5'd1; wd = i;
      if (i == 65535) begin
        #1;
        check("wrap_ffff", {16'h0, wcnt0}, 32'h0000FFFF);
      end
    end
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("wrap_zero_byp", {16'h0, wcnt1}, 32'h0);
    check("wrap_zero_nob", {16'h0, wcnt0}, 32'h0);
    check("wrap_r1", rda1, 32'h0000FFFF);

    // Asynchronous reset mid-cycle while a write is pending.
    write_reg(5'd4, 32'hCAFEF00D);
    ra = 5'd4;
    #1;
    check("r4_set", rda1, 32'hCAFEF00D);
    check("r4_wcount", {16'h0, wcnt1}, 32'd1);
    @(negedge clk);
    we = 1'b1; wa = 5'd4; wd = 32'h00000012;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_r4_byp", rda1, 32'h0);
    check("async_r4_nob", rda0, 32'h0);
    check("async_wcount", {16'h0, wcnt1}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    check("async_r4_release", rda1, 32'h0);
    check("async_wcount_release", {16'h0, wcnt0}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
